// File: rtl/matinv_job_arbiter.sv
// matinv_job_arbiter
// Round-robin scheduler sharing one matrix-inversion engine among R requesters.
// Each job: grant a requester, capture its matrix, pulse the engine reset to
// clear its sticky done, pulse start, wait for done (guarded by a watchdog),
// then hold the result for the owner until it is accepted.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   req              per-requester job request (level)
//   req_matrix       requester r's matrix at [r*W*N*N +: W*N*N]
//   req_ack          one-hot 1-cycle pulse, job accepted
//   rsp_valid        one-hot result valid, held until rsp_ready of the owner
//   rsp_ready        per-requester result accept
//   rsp_matrix       result matrix (zero on timeout)
//   rsp_timeout      qualifies rsp_valid, job was aborted by the watchdog
//   eng_rst          engine reset pulse
//   eng_start        engine start pulse
//   eng_matrix_in    registered copy of the granted matrix
//   eng_done         engine done (sticky until engine reset)
//   eng_matrix_out   engine result
//   busy             high whenever the scheduler is not idle
module matinv_job_arbiter #(
  parameter int N       = 3,
  parameter int W       = 8,
  parameter int R       = 2,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [R-1:0]       req,
  input  logic [R*W*N*N-1:0] req_matrix,
  output logic [R-1:0]       req_ack,
  output logic [R-1:0]       rsp_valid,
  input  logic [R-1:0]       rsp_ready,
  output logic [W*N*N-1:0]   rsp_matrix,
  output logic               rsp_timeout,
  output logic               eng_rst,
  output logic               eng_start,
  output logic [W*N*N-1:0]   eng_matrix_in,
  input  logic               eng_done,
  input  logic [W*N*N-1:0]   eng_matrix_out,
  output logic               busy
);

  localparam int M  = W * N * N;
  localparam int IW = $clog2(R);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [R-1:0] ONE = R'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   r_gnt;
  logic [CW-1:0]   r_cnt;
  logic [R-1:0]    r_req_ack;
  logic [R-1:0]    r_rsp_valid;
  logic [M-1:0]    r_rsp_matrix;
  logic            r_rsp_timeout;
  logic            r_eng_rst;
  logic            r_eng_start;
  logic [M-1:0]    r_eng_matrix_in;
  logic            r_busy;

  logic            w_any;
  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_cand;

  // Round-robin pick: scan from last+1 upward, wrapping; first requester wins.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_cand = '0;
    for (int unsigned k = 1; k <= R; k++) begin
      w_cand = IW'((32'(r_last) + k) % 32'(R));
      if (!w_any && req[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_last          <= IW'(R - 1);
      r_gnt           <= '0;
      r_cnt           <= '0;
      r_req_ack       <= '0;
      r_rsp_valid     <= '0;
      r_rsp_matrix    <= '0;
      r_rsp_timeout   <= 1'b0;
      r_eng_rst       <= 1'b0;
      r_eng_start     <= 1'b0;
      r_eng_matrix_in <= '0;
      r_busy          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt           <= w_win;
            r_last          <= w_win;
            r_eng_matrix_in <= req_matrix[w_win*M +: M];
            // Ack and engine reset are registered so both show in CLEAR.
            r_req_ack       <= ONE << w_win;
            r_eng_rst       <= 1'b1;
            r_busy          <= 1'b1;
            r_state         <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_req_ack   <= '0;
          r_eng_rst   <= 1'b0;
          r_eng_start <= 1'b1;
          r_state     <= S_LAUNCH;
        end
        S_LAUNCH: begin
          r_eng_start <= 1'b0;
          r_cnt       <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          // Done takes priority over a watchdog expiry in the same cycle.
          if (eng_done) begin
            r_rsp_matrix  <= eng_matrix_out;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= ONE << r_gnt;
            r_state       <= S_RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_rsp_matrix  <= '0;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= ONE << r_gnt;
            r_state       <= S_RESP;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready[r_gnt]) begin
            r_rsp_valid <= '0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ack       = r_req_ack;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_matrix    = r_rsp_matrix;
  assign rsp_timeout   = r_rsp_timeout;
  assign eng_rst       = r_eng_rst;
  assign eng_start     = r_eng_start;
  assign eng_matrix_in = r_eng_matrix_in;
  assign busy          = r_busy;

endmodule

// File: tb/tb_matinv_job_arbiter.sv
// Bench for matinv_job_arbiter: directed scenarios followed by randomized jobs,
// checked against a job-level reference (round-robin pick by arithmetic,
// response time from engine latency vs. watchdog limit).
module tb_matinv_job_arbiter;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int R  = 2;
  localparam int TO = 16;
  localparam int M  = W * N * N;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [R-1:0]       req = '0;
  logic [R*M-1:0]     req_matrix = '0;
  logic [R-1:0]       req_ack;
  logic [R-1:0]       rsp_valid;
  logic [R-1:0]       rsp_ready = '0;
  logic [M-1:0]       rsp_matrix;
  logic               rsp_timeout;
  logic               eng_rst;
  logic               eng_start;
  logic [M-1:0]       eng_matrix_in;
  logic               eng_done;
  logic [M-1:0]       eng_matrix_out;
  logic               busy;

  matinv_job_arbiter #(.N(N), .W(W), .R(R), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_matrix     (req_matrix),
    .req_ack        (req_ack),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_matrix     (rsp_matrix),
    .rsp_timeout    (rsp_timeout),
    .eng_rst        (eng_rst),
    .eng_start      (eng_start),
    .eng_matrix_in  (eng_matrix_in),
    .eng_done       (eng_done),
    .eng_matrix_out (eng_matrix_out),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Engine model: done rises eng_lat cycles after the start pulse (0 = never),
  // stays high until the next engine reset.
  int unsigned cyc       = 0;
  int unsigned m_done_at = 0;
  logic        m_armed;
  int unsigned eng_lat   = 0;
  logic [M-1:0] eng_res  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) m_armed <= 1'b0;
    else if (eng_rst) m_armed <= 1'b0;
    else if (eng_start) begin
      m_armed   <= 1'b1;
      m_done_at <= (eng_lat == 0) ? 32'hFFFF_FFFF : cyc + eng_lat;
    end
  end

  assign eng_done       = m_armed && (cyc >= m_done_at);
  assign eng_matrix_out = eng_res;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference state: last granted requester and requests still held.
  int unsigned  mdl_last = R - 1;
  logic [R-1:0] pending  = '0;

  function automatic int unsigned rr_pick(input logic [R-1:0] r, input int unsigned last);
    for (int unsigned k = 1; k <= R; k++)
      if (r[(last + k) % R]) return (last + k) % R;
    return 0;
  endfunction

  function automatic logic [M-1:0] rnd_mat();
    logic [95:0] v;
    v = {$urandom, $urandom, $urandom};
    return v[M-1:0];
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Start a job in the current (IDLE) cycle t; returns after the ack/start checks (at t+2).
  task automatic start_job(input logic [R-1:0] newreq, input int L, input logic [M-1:0] res,
                           input bit rnd, output int unsigned g);
    logic [R-1:0] oh;
    logic [M-1:0] exp_mat;
    if (rnd) req_matrix = {rnd_mat(), rnd_mat()};
    req     = pending | newreq;
    g       = rr_pick(req, mdl_last);
    mdl_last = g;
    oh      = '0;
    oh[g]   = 1'b1;
    exp_mat = req_matrix[g*M +: M];
    eng_lat = L;
    eng_res = res;
    step();                               // t+1
    chk("ack", req_ack, oh);
    chk("eng_rst", eng_rst, 1'b1);
    chk("busy_rise", busy, 1'b1);
    req[g]  = 1'b0;
    pending = req;
    step();                               // t+2
    chk("eng_start", {req_ack, eng_rst, eng_start}, {{R{1'b0}}, 2'b01});
    chk("eng_in", eng_matrix_in, exp_mat);
  endtask

  task automatic run_job(input logic [R-1:0] newreq, input int L, input int bp,
                         input logic [M-1:0] res, input bit rnd);
    int unsigned g;
    int          wt;
    bit          tmo;
    logic [R-1:0] oh;
    logic [M-1:0] exp_res;
    start_job(newreq, L, res, rnd, g);
    tmo     = !(L >= 1 && L <= TO);
    wt      = tmo ? TO : L;
    exp_res = tmo ? '0 : res;
    oh      = '0;
    oh[g]   = 1'b1;
    for (int i = 0; i < wt; i++) step(); // t+2+wt = response cycle - 1
    chk("no_early_rsp", rsp_valid, '0);
    step();                               // response cycle
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_timeout", rsp_timeout, tmo);
    chk("rsp_matrix", rsp_matrix, exp_res);
    for (int i = 0; i < bp; i++) begin
      rsp_ready    = R'($urandom);
      rsp_ready[g] = 1'b0;
      step();
      chk("bp_hold", {req_ack, rsp_valid, rsp_timeout, rsp_matrix},
          {{R{1'b0}}, oh, tmo, exp_res});
    end
    rsp_ready    = R'($urandom);
    rsp_ready[g] = 1'b1;
    step();                               // IDLE after the handshake
    rsp_ready = '0;
    chk("idle_after", {rsp_valid, busy}, '0);
  endtask

  initial begin
    int unsigned g;
    logic [M-1:0] ident;
    logic [M-1:0] seq;

    #1;
    chk("reset_outs", {req_ack, rsp_valid, rsp_matrix, rsp_timeout, eng_rst, eng_start, busy},
        '0);
    chk("reset_eng_in", eng_matrix_in, '0);
    step();
    rst = 1'b0;

    // Single job: identity matrix from requester 0, done 10 cycles after start.
    ident = '0;
    for (int unsigned i = 0; i < N; i++) ident[(i*N + i)*W +: W] = W'(1);
    for (int unsigned i = 0; i < N*N; i++) seq[(N*N - 1 - i)*W +: W] = W'(i + 1);
    req_matrix = {rnd_mat(), ident};
    run_job(2'b01, 10, 0, seq, 1'b0);

    // Timeout (engine never finishes), then a job that must still reset the engine.
    run_job(2'b10, 0, 0, rnd_mat(), 1'b1);
    run_job(2'b01, 5, 0, rnd_mat(), 1'b1);

    // Done in the same cycle the watchdog would expire.
    run_job(2'b10, TO, 1, rnd_mat(), 1'b1);

    // Reset during WAIT: everything clears at once, arbitration restarts at requester 0.
    start_job(2'b01, 0, rnd_mat(), 1'b1, g);
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_wait", {req_ack, rsp_valid, rsp_matrix, rsp_timeout, eng_rst, eng_start, busy},
        '0);
    chk("rst_eng_in", eng_matrix_in, '0);
    mdl_last = R - 1;
    step();
    rst = 1'b0;

    // Contention: both requesters keep asking, ready effectively immediate.
    for (int i = 0; i < 4; i++) run_job(2'b11, $urandom_range(1, 6), 0, rnd_mat(), 1'b1);

    // Backpressure with requester 1 pending.
    run_job(2'b11, 3, 5, rnd_mat(), 1'b1);
    run_job(2'b00, 4, 0, rnd_mat(), 1'b1);

    // Randomized jobs.
    for (int i = 0; i < 30; i++) begin
      logic [R-1:0] nr;
      int sel;
      int L;
      nr = R'($urandom);
      if ((pending | nr) == '0) nr = R'(1) << $urandom_range(0, R - 1);
      sel = $urandom_range(0, 9);
      case (sel)
        0:       L = 0;
        1:       L = TO;
        2:       L = TO + 1;
        default: L = $urandom_range(1, TO - 1);
      endcase
      run_job(nr, L, $urandom_range(0, 4), rnd_mat(), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
